// File: rtl/float_stream_sorter_if.sv
// Valid/ready bundle for float_stream_sorter: an input float stream and a sorted output stream.
// The slave modport is the sorter's view; master is the producer/consumer side.
`ifndef FLEN
`define FLEN 64
`endif

interface float_stream_sorter_if;
  logic              up_valid;
  logic [`FLEN-1:0]  up_data;
  logic              up_ready;
  logic              down_valid;
  logic [`FLEN-1:0]  down_data;
  logic              down_last;
  logic              down_err;
  logic              down_ready;

  modport master (
    output up_valid, up_data, down_ready,
    input  up_ready, down_valid, down_data, down_last, down_err
  );

  modport slave (
    input  up_valid, up_data, down_ready,
    output up_ready, down_valid, down_data, down_last, down_err
  );
endinterface

// File: rtl/float_stream_sorter.sv
// Serial in-place bubble sorter for a batch of N floats using one shared comparator.
// Loads N values, runs (N-1) full passes of compare-swap, then streams them out ascending.
`ifndef FLEN
`define FLEN 64
`endif

module f_less_or_equal (
  input  logic [`FLEN-1:0] a,
  input  logic [`FLEN-1:0] b,
  output logic             res,
  output logic             err
);
  localparam int FLEN = `FLEN;
  localparam int EW   = (FLEN == 64) ? 11 : (FLEN == 32) ? 8 : 5;
  localparam int MW   = FLEN - 1 - EW;

  logic [FLEN-2:0] a_mag, b_mag;
  logic            a_nan, b_nan, both_zero;

  // Sign-magnitude compare; +0 and -0 compare equal, any NaN flags err and forces res low.
  always_comb begin
    a_mag     = a[FLEN-2:0];
    b_mag     = b[FLEN-2:0];
    a_nan     = (&a[FLEN-2 -: EW]) && (|a[MW-1:0]);
    b_nan     = (&b[FLEN-2 -: EW]) && (|b[MW-1:0]);
    both_zero = (a_mag == '0) && (b_mag == '0);
    err       = a_nan | b_nan;
    if (err)                      res = 1'b0;
    else if (both_zero)           res = 1'b1;
    else if (a[FLEN-1] != b[FLEN-1]) res = a[FLEN-1];
    else if (a[FLEN-1])           res = (a_mag >= b_mag);
    else                          res = (a_mag <= b_mag);
  end
endmodule

module float_stream_sorter #(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  float_stream_sorter_if.slave  bus
);
  localparam int FLEN = `FLEN;
  localparam int IW   = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] LAST_CMP = IW'(N - 2);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, idx_nxt;
  logic [IW-1:0]   pass_q, pass_d;
  logic            err_acc_q, err_acc_d;
  logic [FLEN-1:0] mem_q [N];
  logic [FLEN-1:0] mem_d [N];

  logic            up_ready_q, up_ready_d;
  logic            down_valid_q, down_valid_d;
  logic [FLEN-1:0] down_data_q, down_data_d;
  logic            down_last_q, down_last_d;
  logic            down_err_q, down_err_d;

  logic [FLEN-1:0] cmp_a, cmp_b;
  logic            cmp_res, cmp_err;

  assign idx_nxt = idx_q + 1'b1;
  assign cmp_a   = mem_q[idx_q];
  assign cmp_b   = mem_q[idx_nxt];

  f_less_or_equal u_cmp (
    .a   (cmp_a),
    .b   (cmp_b),
    .res (cmp_res),
    .err (cmp_err)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    err_acc_d = err_acc_q;
    mem_d     = mem_q;

    case (state_q)
      LOAD: begin
        if (bus.up_valid) begin
          mem_d[idx_q] = bus.up_data;
          if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            pass_d    = '0;
            err_acc_d = 1'b0;
            state_d   = SORT;
          end else begin
            idx_d = idx_nxt;
          end
        end
      end
      SORT: begin
        // Swap only on strict greater-than so equal keys keep their load order.
        if (!cmp_res) begin
          mem_d[idx_q]   = cmp_b;
          mem_d[idx_nxt] = cmp_a;
        end
        err_acc_d = err_acc_q | cmp_err;
        if (idx_q == LAST_CMP) begin
          idx_d = '0;
          if (pass_q == LAST_CMP) state_d = DRAIN;
          else                    pass_d  = pass_q + 1'b1;
        end else begin
          idx_d = idx_nxt;
        end
      end
      DRAIN: begin
        if (bus.down_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            idx_d = idx_nxt;
          end
        end
      end
      default: state_d = LOAD;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    up_ready_d   = (state_d == LOAD);
    down_valid_d = (state_d == DRAIN);
    down_data_d  = (state_d == DRAIN) ? mem_d[idx_d] : '0;
    down_last_d  = (state_d == DRAIN) && (idx_d == LAST_IDX);
    down_err_d   = (state_d == DRAIN) && err_acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      idx_q        <= '0;
      pass_q       <= '0;
      err_acc_q    <= 1'b0;
      up_ready_q   <= 1'b1;
      down_valid_q <= 1'b0;
      down_data_q  <= '0;
      down_last_q  <= 1'b0;
      down_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pass_q       <= pass_d;
      err_acc_q    <= err_acc_d;
      up_ready_q   <= up_ready_d;
      down_valid_q <= down_valid_d;
      down_data_q  <= down_data_d;
      down_last_q  <= down_last_d;
      down_err_q   <= down_err_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.up_ready   = up_ready_q;
  assign bus.down_valid = down_valid_q;
  assign bus.down_data  = down_data_q;
  assign bus.down_last  = down_last_q;
  assign bus.down_err   = down_err_q;
endmodule

// File: tb/tb_float_stream_sorter.sv
// Directed bench for float_stream_sorter (N = 4, FP64): table of batches with expected
// sorted output, plus backpressure and asynchronous-reset recovery sequences.
module tb_float_stream_sorter;
  typedef logic [3:0][63:0] quad_t;
  typedef struct packed {
    quad_t in_v;
    quad_t exp_v;
    logic  exp_err;
    logic  ordered;
  } vec_t;

  localparam logic [63:0] P2   = 64'h4000000000000000;
  localparam logic [63:0] P1   = 64'h3FF0000000000000;
  localparam logic [63:0] PH   = 64'h3FE0000000000000;
  localparam logic [63:0] M1   = 64'hBFF0000000000000;
  localparam logic [63:0] PZ   = 64'h0000000000000000;
  localparam logic [63:0] MZ   = 64'h8000000000000000;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;
  localparam logic [63:0] P3   = 64'h4008000000000000;
  localparam logic [63:0] M2   = 64'hC000000000000000;
  localparam logic [63:0] PQ   = 64'h3FD0000000000000;
  localparam logic [63:0] P15  = 64'h3FF8000000000000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  vec_t vecs [5];

  float_stream_sorter_if bus ();

  float_stream_sorter #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic quad_t q4(input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] c, input logic [63:0] d);
    quad_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Loads the first 'count' values; optionally inserts an idle cycle with junk data before value 2.
  task automatic applyStimulus(input quad_t v, input int count, input bit gap);
    int i = 0;
    int budget = 0;
    bit gapped = 1'b0;
    while (i < count && budget < 50) begin
      @(negedge clk);
      budget++;
      if (gap && i == 2 && !gapped) begin
        bus.up_valid = 1'b0;
        bus.up_data  = 64'hDEADBEEFDEADBEEF;
        gapped = 1'b1;
      end else begin
        bus.up_valid = 1'b1;
        bus.up_data  = v[i];
        if (bus.up_ready) begin
          i++;
          accept_cyc = cyc + 1;
        end
      end
    end
    @(negedge clk);
    bus.up_valid = 1'b0;
    bus.up_data  = '0;
    checkOutput("load accepted", 64'(i), 64'(count));
  endtask

  // stall_mode 1: hold down_ready low 5 cycles after valid, then alternate 1/0.
  task automatic collectBatch(input vec_t v, input int stall_mode);
    int budget = 0;
    int beat = 0;
    int t = 0;
    bit stalled = 1'b0;
    bit rdy;
    logic [63:0] held_data;
    logic        held_last, held_err;
    logic [63:0] got [4];
    int cnt_in, cnt_out;
    while (!bus.down_valid && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("latency", 64'(cyc - accept_cyc), 64'd9);
    budget = 0;
    while (beat < 4 && budget < 100) begin
      if (stalled) begin
        checkOutput("stall data stable", bus.down_data, held_data);
        checkOutput("stall last stable", 64'(bus.down_last), 64'(held_last));
        checkOutput("stall err stable", 64'(bus.down_err), 64'(held_err));
      end
      checkOutput("up_ready low in drain", 64'(bus.up_ready), 64'd0);
      rdy = (stall_mode == 0) || (t >= 5 && ((t - 5) % 2 == 0));
      bus.down_ready = rdy;
      if (rdy) begin
        checkOutput("down_valid", 64'(bus.down_valid), 64'd1);
        if (v.ordered) checkOutput("down_data", bus.down_data, v.exp_v[beat]);
        got[beat] = bus.down_data;
        checkOutput("down_last", 64'(bus.down_last), 64'(beat == 3));
        checkOutput("down_err", 64'(bus.down_err), 64'(v.exp_err));
        beat++;
        stalled = 1'b0;
      end else begin
        stalled   = 1'b1;
        held_data = bus.down_data;
        held_last = bus.down_last;
        held_err  = bus.down_err;
      end
      t++;
      budget++;
      @(negedge clk);
    end
    bus.down_ready = 1'b0;
    checkOutput("beats drained", 64'(beat), 64'd4);
    checkOutput("up_ready after drain", 64'(bus.up_ready), 64'd1);
    checkOutput("down_valid after drain", 64'(bus.down_valid), 64'd0);
    if (!v.ordered) begin
      for (int j = 0; j < 4; j++) begin
        cnt_in  = 0;
        cnt_out = 0;
        for (int m = 0; m < 4; m++) begin
          if (v.in_v[m] === v.in_v[j]) cnt_in++;
          if (got[m] === v.in_v[j]) cnt_out++;
        end
        checkOutput("permutation count", 64'(cnt_out), 64'(cnt_in));
      end
    end
  endtask

  // Asynchronous pulse between clock edges; called at a falling edge.
  task automatic pulseReset();
    bus.up_valid   = 1'b0;
    bus.down_ready = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    checkOutput("reset down_valid", 64'(bus.down_valid), 64'd0);
    checkOutput("reset up_ready", 64'(bus.up_ready), 64'd1);
    checkOutput("reset down_data", bus.down_data, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    int budget;
    bus.up_valid   = 1'b0;
    bus.up_data    = '0;
    bus.down_ready = 1'b0;

    vecs[0] = '{in_v: q4(P2, P1, PH, M1),   exp_v: q4(M1, PH, P1, P2),  exp_err: 1'b0, ordered: 1'b1};
    vecs[1] = '{in_v: q4(M1, P1, P1, P2),   exp_v: q4(M1, P1, P1, P2),  exp_err: 1'b0, ordered: 1'b1};
    vecs[2] = '{in_v: q4(PZ, MZ, M1, PZ),   exp_v: q4(M1, PZ, MZ, PZ),  exp_err: 1'b0, ordered: 1'b1};
    vecs[3] = '{in_v: q4(P1, QNAN, PH, P2), exp_v: q4(P1, QNAN, PH, P2), exp_err: 1'b1, ordered: 1'b0};
    vecs[4] = '{in_v: q4(P3, M2, PQ, P15),  exp_v: q4(M2, PQ, P15, P3), exp_err: 1'b0, ordered: 1'b1};

    repeat (2) @(negedge clk);
    checkOutput("in reset down_valid", 64'(bus.down_valid), 64'd0);
    checkOutput("in reset down_data", bus.down_data, 64'd0);
    checkOutput("in reset down_last", 64'(bus.down_last), 64'd0);
    checkOutput("in reset down_err", 64'(bus.down_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post reset up_ready", 64'(bus.up_ready), 64'd1);

    for (int k = 0; k < 5; k++) begin
      applyStimulus(vecs[k].in_v, 4, k == 4);
      collectBatch(vecs[k], 0);
    end

    applyStimulus(vecs[0].in_v, 4, 1'b0);
    collectBatch(vecs[0], 1);

    applyStimulus(vecs[1].in_v, 2, 1'b0);
    pulseReset();
    applyStimulus(vecs[2].in_v, 4, 1'b0);
    collectBatch(vecs[2], 0);

    applyStimulus(vecs[0].in_v, 4, 1'b0);
    repeat (3) @(negedge clk);
    pulseReset();
    applyStimulus(vecs[1].in_v, 4, 1'b0);
    collectBatch(vecs[1], 0);

    applyStimulus(vecs[4].in_v, 4, 1'b0);
    budget = 0;
    while (!bus.down_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("drain reached", 64'(bus.down_valid), 64'd1);
    bus.down_ready = 1'b1;
    @(negedge clk);
    bus.down_ready = 1'b0;
    pulseReset();
    applyStimulus(vecs[0].in_v, 4, 1'b0);
    collectBatch(vecs[0], 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
